// File: rtl/prach_hb_dec2.sv
// Half-band decimate-by-2 stage for the long-PRACH chain.
// Six independent lanes (3 CC x I/Q) share the channel-phase strobes.
// The filter keeps the newest sample on every output (even-phase decimation).
module prach_hb_dec2 #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din_dr [3],
  input  logic signed [DW-1:0] din_di [3],
  input  logic [7:0]           din_chn,
  input  logic                 sync_in,
  output logic signed [DW-1:0] dout_dr [3],
  output logic signed [DW-1:0] dout_di [3],
  output logic                 dout_valid,
  output logic [7:0]           dout_chn,
  output logic                 sync_out,
  output logic                 sync_err
);

  localparam int unsigned NCC  = 3;
  localparam int unsigned NL   = 2 * NCC;
  localparam int unsigned TAPS = 7;
  localparam int          AW   = DW + 6;
  localparam logic signed [AW-1:0] SAT_HI = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO = -SAT_HI - AW'(1);

  logic signed [DW-1:0] lane_in [NL];
  logic signed [DW-1:0] dly     [NL][TAPS];
  logic signed [DW+1:0] p_edge  [NL];
  logic signed [DW:0]   p_mid   [NL];
  logic signed [DW-1:0] p_ctr   [NL];
  logic signed [AW-1:0] acc     [NL];
  logic signed [AW-1:0] rnd     [NL];
  logic signed [DW-1:0] y_sat   [NL];
  logic signed [DW-1:0] y_reg   [NL];

  logic       samp_stb;
  logic       comp_stb;
  logic       comp_d1;
  logic       comp_d2;
  logic [7:0] chn_d1;
  logic [7:0] chn_d2;
  logic       sync_d1;
  logic       sync_d2;
  logic       sync_ok;
  logic       sync_bad;

  assign samp_stb = (din_chn[2:0] == 3'd0);
  assign comp_stb = (din_chn[3:0] == 4'd0);
  assign sync_ok  = sync_in && (din_chn == 8'd0);
  assign sync_bad = sync_in && (din_chn != 8'd0);

  // Flatten the CC ports into lanes: 0..2 are I, 3..5 are Q.
  always_comb begin
    for (int unsigned c = 0; c < NCC; c++) begin
      lane_in[c]       = din_dr[c];
      lane_in[c + NCC] = din_di[c];
    end
  end

  // Per-lane 7-deep delay lines, shifted only on sample strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned l = 0; l < NL; l++) begin
        for (int unsigned k = 0; k < TAPS; k++) begin
          dly[l][k] <= '0;
        end
      end
    end else if (samp_stb) begin
      for (int unsigned l = 0; l < NL; l++) begin
        dly[l][0] <= lane_in[l];
        for (int unsigned k = 1; k < TAPS; k++) begin
          dly[l][k] <= dly[l][k-1];
        end
      end
    end
  end

  // Symmetric-pair partial sums; the zero taps x1/x5 are never read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned l = 0; l < NL; l++) begin
        p_edge[l] <= '0;
        p_mid[l]  <= '0;
        p_ctr[l]  <= '0;
      end
    end else begin
      for (int unsigned l = 0; l < NL; l++) begin
        p_edge[l] <= -(DW+2)'(dly[l][0]) - (DW+2)'(dly[l][TAPS-1]);
        p_mid[l]  <= (DW+1)'(dly[l][2]) + (DW+1)'(dly[l][4]);
        p_ctr[l]  <= dly[l][3];
      end
    end
  end

  // Shift-add weighting (9x = 8x + x, 16x), round half-up, saturate.
  always_comb begin
    for (int unsigned l = 0; l < NL; l++) begin
      acc[l] = AW'(p_edge[l]) + (AW'(p_mid[l]) <<< 3) + AW'(p_mid[l])
             + (AW'(p_ctr[l]) <<< 4);
      rnd[l] = (acc[l] + AW'(16)) >>> 5;
      if (rnd[l] > SAT_HI) begin
        y_sat[l] = SAT_HI[DW-1:0];
      end else if (rnd[l] < SAT_LO) begin
        y_sat[l] = SAT_LO[DW-1:0];
      end else begin
        y_sat[l] = rnd[l][DW-1:0];
      end
    end
  end

  // Compute-strobe pipeline and held output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_d1    <= 1'b0;
      comp_d2    <= 1'b0;
      dout_valid <= 1'b0;
      for (int unsigned l = 0; l < NL; l++) begin
        y_reg[l] <= '0;
      end
    end else begin
      comp_d1    <= comp_stb;
      comp_d2    <= comp_d1;
      dout_valid <= comp_d2;
      if (comp_d2) begin
        for (int unsigned l = 0; l < NL; l++) begin
          y_reg[l] <= y_sat[l];
        end
      end
    end
  end

  // Phase and sync follow the data through the same 3-clock latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chn_d1   <= '0;
      chn_d2   <= '0;
      dout_chn <= '0;
      sync_d1  <= 1'b0;
      sync_d2  <= 1'b0;
      sync_out <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      chn_d1   <= din_chn;
      chn_d2   <= chn_d1;
      dout_chn <= chn_d2;
      sync_d1  <= sync_ok;
      sync_d2  <= sync_d1;
      sync_out <= sync_d2;
      if (sync_bad) begin
        sync_err <= 1'b1;
      end
    end
  end

  // Unflatten lanes back onto the CC output ports.
  always_comb begin
    for (int unsigned c = 0; c < NCC; c++) begin
      dout_dr[c] = y_reg[c];
      dout_di[c] = y_reg[c + NCC];
    end
  end

endmodule

// File: tb/tb_prach_hb_dec2.sv
// Self-checking bench for prach_hb_dec2 against a sample-history reference.
module tb_prach_hb_dec2;

  localparam int DW   = 16;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] din_dr [3];
  logic signed [DW-1:0] din_di [3];
  logic [7:0]           din_chn;
  logic                 sync_in;
  logic signed [DW-1:0] dout_dr [3];
  logic signed [DW-1:0] dout_di [3];
  logic                 dout_valid;
  logic [7:0]           dout_chn;
  logic                 sync_out;
  logic                 sync_err;

  int n_tests;
  int n_fail;

  prach_hb_dec2 #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_dr     (din_dr),
    .din_di     (din_di),
    .din_chn    (din_chn),
    .sync_in    (sync_in),
    .dout_dr    (dout_dr),
    .dout_di    (dout_di),
    .dout_valid (dout_valid),
    .dout_chn   (dout_chn),
    .sync_out   (sync_out),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: input sample history per lane, 3-clock result latency.
  int         hist [6][7];
  int         held [6];
  bit         pv [3];
  int         py [3][6];
  int         pchn [3];
  bit         psync [3];
  bit         m_err;
  logic [7:0] chn;
  int         cap_lane;
  int         cap_q [$];

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tap(input int k);
    case (k)
      0, 6:    return -1;
      2, 4:    return 9;
      3:       return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_out(input int l);
    int s;
    int q;
    s = 16;
    for (int k = 0; k < 7; k++) s += tap(k) * hist[l][k];
    q = (s >= 0) ? s / 32 : -((-s + 31) / 32);
    if (q > MAXV) q = MAXV;
    if (q < MINV) q = MINV;
    return q;
  endfunction

  function automatic int lane_val(input int l);
    return (l < 3) ? int'(din_dr[l]) : int'(din_di[l-3]);
  endfunction

  function automatic int dut_lane(input int l);
    return (l < 3) ? int'(dout_dr[l]) : int'(dout_di[l-3]);
  endfunction

  task automatic model_clear();
    for (int l = 0; l < 6; l++) begin
      held[l] = 0;
      for (int k = 0; k < 7; k++) hist[l][k] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      pv[i] = 0; pchn[i] = 0; psync[i] = 0;
      for (int l = 0; l < 6; l++) py[i][l] = 0;
    end
    m_err = 0;
  endtask

  // Apply what the DUT sees at the coming clock edge.
  task automatic model_edge();
    if (rst) begin
      model_clear();
    end else begin
      if (din_chn[2:0] == 3'd0) begin
        for (int l = 0; l < 6; l++) begin
          for (int k = 6; k > 0; k--) hist[l][k] = hist[l][k-1];
          hist[l][0] = lane_val(l);
        end
      end
      for (int i = 2; i > 0; i--) begin
        pv[i] = pv[i-1]; pchn[i] = pchn[i-1]; psync[i] = psync[i-1];
        for (int l = 0; l < 6; l++) py[i][l] = py[i-1][l];
      end
      pv[0]    = (din_chn[3:0] == 4'd0);
      pchn[0]  = int'(din_chn);
      psync[0] = sync_in && (din_chn == 8'd0);
      for (int l = 0; l < 6; l++) py[0][l] = pv[0] ? ref_out(l) : 0;
      if (sync_in && din_chn != 8'd0) m_err = 1;
      if (pv[2]) for (int l = 0; l < 6; l++) held[l] = py[2][l];
    end
  endtask

  task automatic compare_all();
    chk("valid", dout_valid, pv[2]);
    chk("chn", dout_chn, pchn[2]);
    chk("sync_out", sync_out, psync[2]);
    chk("sync_err", sync_err, m_err);
    for (int l = 0; l < 6; l++) chk($sformatf("lane%0d", l), dut_lane(l), held[l]);
  endtask

  task automatic tick();
    din_chn = chn;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    if (cap_lane >= 0 && dout_valid) cap_q.push_back(dut_lane(cap_lane));
    chn = chn + 8'd1;
  endtask

  task automatic set_lane(input int l, input int v);
    if (l < 3) din_dr[l] = DW'(v);
    else       din_di[l-3] = DW'(v);
  endtask

  task automatic set_all(input int v);
    for (int l = 0; l < 6; l++) set_lane(l, v);
  endtask

  task automatic align(input int m);
    for (int i = 0; i < 16 && int'(chn[3:0]) != m; i++) tick();
  endtask

  task automatic chk_cap(input string tag, input int idx, input int exp);
    if (idx < cap_q.size()) chk($sformatf("%s[%0d]", tag, idx), cap_q[idx], exp);
    else chk($sformatf("%s[%0d]_missing", tag, idx), -999999, exp);
  endtask

  task automatic impulse(input int l, input int phase, input int amp);
    align(phase);
    cap_q.delete();
    cap_lane = l;
    set_lane(l, amp);
    tick();
    set_lane(l, 0);
    repeat (80) tick();
    cap_lane = -1;
  endtask

  task automatic feed(input int s0, input int s1, input int s2, input int s3,
                      input int s4, input int s5, input int s6);
    int seq [7];
    seq = '{s0, s1, s2, s3, s4, s5, s6};
    align(0);
    for (int i = 0; i < 7; i++) begin
      set_all(seq[i]);
      repeat (8) tick();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", dout_valid, 0);
    chk("rst_chn", dout_chn, 0);
    chk("rst_sync_out", sync_out, 0);
    chk("rst_sync_err", sync_err, 0);
    for (int l = 0; l < 6; l++) chk($sformatf("rst_lane%0d", l), dut_lane(l), 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    n_tests  = 0;
    n_fail   = 0;
    cap_lane = -1;
    chn      = 8'd0;
    rst      = 1'b1;
    sync_in  = 1'b0;
    din_chn  = 8'd0;
    set_all(0);
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();

    // Even-phase impulse on cc0 I.
    impulse(0, 0, 1024);
    chk_cap("even", 0, -32);
    chk_cap("even", 1, 288);
    chk_cap("even", 2, 288);
    chk_cap("even", 3, -32);
    chk_cap("even", 4, 0);

    // Odd-phase impulses on cc1 Q.
    impulse(4, 8, 1024);
    chk_cap("odd", 0, 0);
    chk_cap("odd", 1, 512);
    chk_cap("odd", 2, 0);
    chk_cap("odd", 3, 0);
    impulse(4, 8, 1);
    chk_cap("odd_p1", 1, 1);
    impulse(4, 8, -1);
    chk_cap("odd_m1", 1, 0);

    // DC extremes.
    set_all(MAXV);
    repeat (80) tick();
    for (int l = 0; l < 6; l++) chk($sformatf("dc_pos%0d", l), dut_lane(l), MAXV);
    set_all(MINV);
    repeat (80) tick();
    for (int l = 0; l < 6; l++) chk($sformatf("dc_neg%0d", l), dut_lane(l), MINV);

    // Overshoot saturation, both signs.
    feed(MINV, 0, MAXV, MAXV, MAXV, 0, MINV);
    for (int l = 0; l < 6; l++) chk($sformatf("sat_hi%0d", l), dut_lane(l), MAXV);
    feed(MAXV, 0, MINV, MINV, MINV, 0, MAXV);
    for (int l = 0; l < 6; l++) chk($sformatf("sat_lo%0d", l), dut_lane(l), MINV);

    // Legal and illegal sync.
    set_all(0);
    for (int i = 0; i < 256 && chn != 8'd0; i++) tick();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    tick();
    tick();
    chk("sync_fwd", sync_out, 1);
    chk("sync_chn", dout_chn, 0);
    chk("sync_valid", dout_valid, 1);
    for (int i = 0; i < 256 && chn != 8'd5; i++) tick();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    chk("sync_err_set", sync_err, 1);
    repeat (3) tick();
    chk("sync_bad_drop", sync_out, 0);

    // Random traffic with phase jumps and a mid-stream reset.
    for (int n = 0; n < 1500; n++) begin
      for (int l = 0; l < 6; l++) begin
        r = 16'($urandom);
        if ($urandom_range(0, 9) == 0) r = ($urandom_range(0, 1) == 0) ? 16'h7fff : 16'h8000;
        set_lane(l, int'($signed(r)));
      end
      if ($urandom_range(0, 199) == 0) chn = 8'($urandom);
      sync_in = (chn == 8'd0) ? 1'($urandom_range(0, 1))
                              : ($urandom_range(0, 999) == 0);
      if (n == 700) pulse_reset();
      else tick();
    end
    sync_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prach_hb_dec2.md
# prach_hb_dec2

Half-band decimate-by-2 stage for the long-PRACH chain. It sits directly downstream of the channel-phase resync stage and takes three carrier components (CC) of 61.44 Msps I/Q. Inputs arrive as parallel lanes with 8 clock ticks per sample, together with the free-running 8-bit channel phase and the sync pulse. It outputs three CCs at 30.72 Msps, one result every 16 ticks, with phase and sync re-aligned to the output.

## Interface
- DW, 16, sample width (signed two's complement) for I and Q, in and out.
- clk  in  1  processing clock, 8 ticks per 61.44 Msps sample.
- rst  in  1  reset; one clock, asynchronous, active-high.
- din_dr  in  DW×[3]  I sample per CC.
- din_di  in  DW×[3]  Q sample per CC.
- din_chn  in  8  upstream channel phase; increments by 1 per clock and wraps 255→0.
- sync_in  in  1  frame sync pulse; legal only when din_chn == 0.
- dout_dr  out  DW×[3]  decimated I per CC, held between updates.
- dout_di  out  DW×[3]  decimated Q per CC, held between updates.
- dout_valid  out  1  one-cycle pulse when dout_dr/dout_di update.
- dout_chn  out  8  din_chn delayed by 3 clocks.
- sync_out  out  1  sync_in delayed by 3 clocks, legal pulses only.
- sync_err  out  1  sticky flag: sync_in seen with din_chn != 0.

## Operation
- **Sample strobe:** din_chn[2:0] == 0. On each strobe, the six per-lane 7-deep delay lines shift: x0 ← din, xk ← xk-1. No other cycle changes them.
- **Compute strobe:** din_chn[3:0] == 0, which is every second sample strobe. The newest sample is always part of the output (even-phase decimation).
- **Filter:** y = (−x0 + 9·x2 + 16·x3 + 9·x4 − x6) / 32. DC gain is exactly 1.
  - Multiplies are shift-add only: 9x = (x<<3)+x, 16x = x<<4.
- **Accumulator:** 22-bit signed; it must not overflow for any input.
- **Rounding:** add 16, then arithmetic shift right by 5. This is round-half-up (toward +inf).
- **Saturation:** clamp to [−2^(DW−1), 2^(DW−1)−1]. Overshoot is possible because Σ|h| = 36/32.
- **Lanes:** all 6 lanes (3 CC × I/Q) use identical independent datapaths.
- **Sync:**
  - sync_in with din_chn == 0 is forwarded unchanged through the 3-stage delay to sync_out.
  - sync_in with din_chn != 0 is dropped (sync_out stays 0) and sets sync_err. sync_err is cleared only by rst.
- Sync never clears the delay lines; the filter history stays continuous across resyncs.
- **dout_chn:** a pure 3-stage delay of din_chn, not a local counter.
- **Reset (async, mid-operation included):**
  - All delay lines, pipeline registers, dout_dr, dout_di, dout_chn, dout_valid, sync_out and sync_err go to 0 immediately.
  - After release, the first dout_valid follows the first compute strobe. Its result uses zero history.

## Timing
- **Cycle t** (compute strobe, din sampled): delay line registered at end of t.
- **Cycle t+1:** partial sums (−x0−x6, x2+x4, x3) registered.
- **Cycle t+2:** the weighted sum, round and saturate are registered into dout_*.
- **Visible at t+3:**
  - dout_valid = 1 for exactly cycle t+3.
  - dout_dr/dout_di hold until the next valid pulse, 16 clocks later.
- **Alignment:**
  - dout_chn is din_chn from 3 clocks earlier, so dout_valid coincides with dout_chn[3:0] == 0.
  - sync_out coincides with dout_valid and dout_chn == 0.
- **Throughput:** one output per CC per 16 clocks. There is no back-pressure.
- **Phase jumps:** if din_chn jumps (upstream resync), strobes follow the new din_chn with no further latency. A compute strobe is never skipped or doubled relative to the din_chn values actually presented.

## Test plan
- **Even impulse:** cc0 I = 1024 at one compute strobe, else 0 → successive cc0 dout_dr = −32, 288, 288, −32, then 0. Other lanes stay 0.
- **Odd impulse:** cc1 Q = 1024 on the sample strobe between compute strobes (din_chn[3:0] == 8) → cc1 dout_di = 0, 512, 0, 0.
  - With amplitude 1: 1 (half rounds up).
  - With amplitude −1: 0.
- **DC:** all lanes constant +32767 → 32767; constant −32768 → −32768. No wrap.
- **Saturation:** x0 = x6 = −32768 and x2 = x3 = x4 = +32767 at a compute strobe → 32767. Negated pattern → −32768.
- **Sync:**
  - sync_in at din_chn == 0 → sync_out = 1 three clocks later, with dout_chn == 0 and dout_valid = 1.
  - sync_in at din_chn == 5 → sync_out stays 0 and sync_err = 1 until rst.
- **Reset mid-stream:** assert rst for 1 clock during random traffic → all outputs read 0 the same cycle. After release, outputs match a reference model started from zero history.
